// File: rtl/mantissa_align_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mantissa_align_shifter_pipe
//  Purpose  : Pipelined logarithmic right shifter for floating-point exponent
//             alignment. It produces guard, round and sticky bits, and has one
//             log-shifter stage per register.
//  Revision : 1.0 - initial pipelined, parametrised release
//
//  Ports
//    clk         rising-edge clock
//    rst_n       synchronous active-low reset (flushes the pipe)
//    in_valid    operand valid            in_ready   operand accepted this cycle
//    in_mant     N-bit mantissa           in_shift   right-shift amount
//    in_tag      sideband tag, passed through unchanged
//    out_valid   result valid             out_ready  downstream accepts result
//    out_mant    aligned mantissa
//    out_guard   first bit below the LSB of out_mant
//    out_round   second bit below the LSB of out_mant
//    out_sticky  OR of all bits shifted out beyond the round bit
//    out_tag     tag of the result
//
//  Build option
//    ALIGN_BIDIR_EN : adds in_dir. With in_dir = 1 the operand is shifted
//                     left (normalisation), and guard/round/sticky are 0.
// ============================================================================
module mantissa_align_shifter_pipe #(
    parameter int N     = 11,
    parameter int SHW   = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_mant,
    input  logic [SHW-1:0]   in_shift,
    input  logic [TAG_W-1:0] in_tag,
`ifdef ALIGN_BIDIR_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_mant,
    output logic             out_guard,
    output logic             out_round,
    output logic             out_sticky,
    output logic [TAG_W-1:0] out_tag
);

    // The extended vector carries the mantissa plus guard and round positions.
    localparam int c_EW = N + 2;

    // A single global advance keeps every stage in lockstep. Bubbles are not
    // collapsed, so acceptance depends only on the last stage.
    logic w_adv;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            localparam int c_AMT = 1 << k;

            // Stage k consumes bit 0 of its remaining shift vector. The upper
            // bits move on to later stages, so the vector narrows by one each stage.
            logic [SHW-1-k:0] w_sh;
            logic [c_EW-1:0]  w_e_in;
            logic [c_EW-1:0]  w_e_nx;
            logic             w_s_in;
            logic             w_s_nx;
            logic             w_v_in;
            logic [TAG_W-1:0] w_tag_in;
`ifdef ALIGN_BIDIR_EN
            logic             w_dir;
`endif
            logic [c_EW-1:0]  r_e;
            logic             r_s;
            logic             r_v;
            logic [TAG_W-1:0] r_tag;

            if (k == 0) begin : g_src_port
                assign w_sh     = in_shift;
                assign w_e_in   = {in_mant, 2'b00};
                assign w_s_in   = 1'b0;
                assign w_v_in   = in_valid;
                assign w_tag_in = in_tag;
`ifdef ALIGN_BIDIR_EN
                assign w_dir    = in_dir;
`endif
            end else begin : g_src_prev
                assign w_sh     = g_stage[k-1].g_pass.r_sh;
                assign w_e_in   = g_stage[k-1].r_e;
                assign w_s_in   = g_stage[k-1].r_s;
                assign w_v_in   = g_stage[k-1].r_v;
                assign w_tag_in = g_stage[k-1].r_tag;
`ifdef ALIGN_BIDIR_EN
                assign w_dir    = g_stage[k-1].g_pass.r_dir;
`endif
            end

            if (c_AMT >= c_EW) begin : g_full
                // This stage's shift distance is wider than the whole vector,
                // so every bit either falls into sticky or off the top.
                always_comb begin
                    w_e_nx = w_e_in;
                    w_s_nx = w_s_in;
                    if (w_sh[0]) begin
                        w_e_nx = '0;
`ifdef ALIGN_BIDIR_EN
                        if (!w_dir) begin
                            w_s_nx = w_s_in | (|w_e_in);
                        end
`else
                        w_s_nx = w_s_in | (|w_e_in);
`endif
                    end
                end
            end else begin : g_part
                always_comb begin
                    w_e_nx = w_e_in;
                    w_s_nx = w_s_in;
                    if (w_sh[0]) begin
`ifdef ALIGN_BIDIR_EN
                        // A left shift never accumulates sticky. The low two
                        // bits start at zero and stay zero, so G/R read as 0.
                        if (w_dir) begin
                            w_e_nx = w_e_in << c_AMT;
                        end else begin
                            w_s_nx = w_s_in | (|w_e_in[c_AMT-1:0]);
                            w_e_nx = w_e_in >> c_AMT;
                        end
`else
                        w_s_nx = w_s_in | (|w_e_in[c_AMT-1:0]);
                        w_e_nx = w_e_in >> c_AMT;
`endif
                    end
                end
            end

            // A bubble still loads its (deterministic) data; only the valid bit is 0.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_v   <= 1'b0;
                    r_e   <= '0;
                    r_s   <= 1'b0;
                    r_tag <= '0;
                end else if (w_adv) begin
                    r_v   <= w_v_in;
                    r_e   <= w_e_nx;
                    r_s   <= w_s_nx;
                    r_tag <= w_tag_in;
                end
            end

            // Later stages still need the unconsumed shift bits (and direction).
            if (k < SHW - 1) begin : g_pass
                logic [SHW-2-k:0] r_sh;
`ifdef ALIGN_BIDIR_EN
                logic             r_dir;
`endif
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_sh  <= '0;
`ifdef ALIGN_BIDIR_EN
                        r_dir <= 1'b0;
`endif
                    end else if (w_adv) begin
                        r_sh  <= w_sh[SHW-1-k:1];
`ifdef ALIGN_BIDIR_EN
                        r_dir <= w_dir;
`endif
                    end
                end
            end
        end
    endgenerate

    assign w_adv      = !g_stage[SHW-1].r_v | out_ready;
    assign in_ready   = w_adv;

    assign out_valid  = g_stage[SHW-1].r_v;
    assign out_mant   = g_stage[SHW-1].r_e[c_EW-1:2];
    assign out_guard  = g_stage[SHW-1].r_e[1];
    assign out_round  = g_stage[SHW-1].r_e[0];
    assign out_sticky = g_stage[SHW-1].r_s;
    assign out_tag    = g_stage[SHW-1].r_tag;

endmodule
`default_nettype wire
